// File: rtl/umi_reghost_pkg.sv
// UMI register host: shared opcodes and the local FSM state encoding.
package umi_reghost_pkg;

    // UMI request/response opcodes (cmd[4:0]), as in umi_messages.vh
    localparam logic [4:0] UMI_REQ_READ   = 5'h01;
    localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
    localparam logic [4:0] UMI_REQ_POSTED = 5'h05;
    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/umi_reghost.sv
// UMI register host: turns single register read/write/posted requests from a
// local controller into UMI requests, waits for the response (with optional
// timeout) and returns read data plus completion status.
module umi_reghost
    import umi_reghost_pkg::*;
#(
    parameter int RW  = 32,
    parameter int CW  = 32,
    parameter int AW  = 64,
    parameter int DW  = 64,
    parameter logic [AW-1:0] HOSTADDR = '0,
    parameter int TOW = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          reg_valid,
    input  logic          reg_write,
    input  logic          reg_posted,
    input  logic [AW-1:0] reg_addr,
    input  logic [RW-1:0] reg_wdata,
    output logic          reg_ready,
    output logic          reg_done,
    output logic [RW-1:0] reg_rdata,
    output logic [1:0]    reg_err,
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    // counter keeps at least one bit so TOW=0 still elaborates; the compare is gated off
    localparam int CNTW    = (TOW > 0) ? TOW : 1;
    localparam int TIMEOUT = (TOW > 0) ? (2 ** TOW) - 1 : 1;
    // the counter starts at 0 in the first WAIT cycle, so the last WAIT cycle sees TIMEOUT-1
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [2:0]      SIZE     = 3'($clog2(RW / 8));

    // single-beat command word: opcode, size, everything else zero
    function automatic logic [CW-1:0] pack_cmd(input logic [4:0] opcode);
        logic [CW-1:0] c;
        c      = '0;
        c[4:0] = opcode;
        c[7:5] = SIZE;
        return c;
    endfunction

    function automatic logic [DW-1:0] zext_data(input logic [RW-1:0] d);
        logic [DW-1:0] r;
        r         = '0;
        r[RW-1:0] = d;
        return r;
    endfunction

    state_t          state;
    logic            is_read;
    logic            is_posted;
    logic [CNTW-1:0] cnt;
    logic [4:0]      resp_op;
    logic            resp_match;
    logic            timeout_hit;
    logic            unused_bits;

    assign reg_ready         = (state == ST_IDLE);
    assign uhost_req_srcaddr = HOSTADDR;
    assign uhost_resp_ready  = 1'b1;
    assign resp_op           = uhost_resp_cmd[4:0];
    assign timeout_hit       = (TOW != 0) && (cnt == CNT_LAST);
    assign unused_bits       = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                                 uhost_resp_cmd, uhost_resp_data};

    // response opcode must match the kind of request outstanding
    always_comb begin
        resp_match = 1'b0;
        if (is_read) resp_match = (resp_op == UMI_RESP_READ);
        else         resp_match = (resp_op == UMI_RESP_WRITE);
    end

    // transaction FSM with registered request and completion outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state             <= ST_IDLE;
            is_read           <= 1'b0;
            is_posted         <= 1'b0;
            cnt               <= '0;
            reg_done          <= 1'b0;
            reg_rdata         <= '0;
            reg_err           <= '0;
            uhost_req_valid   <= 1'b0;
            uhost_req_cmd     <= '0;
            uhost_req_dstaddr <= '0;
            uhost_req_data    <= '0;
        end else begin
            reg_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (reg_valid) begin
                        is_read           <= ~reg_write;
                        is_posted         <= reg_write & reg_posted;
                        uhost_req_dstaddr <= reg_addr;
                        uhost_req_valid   <= 1'b1;
                        if (!reg_write) begin
                            uhost_req_cmd  <= pack_cmd(UMI_REQ_READ);
                            uhost_req_data <= '0;
                        end else begin
                            uhost_req_cmd  <= pack_cmd(reg_posted ? UMI_REQ_POSTED
                                                                  : UMI_REQ_WRITE);
                            uhost_req_data <= zext_data(reg_wdata);
                        end
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (uhost_req_ready) begin
                        uhost_req_valid <= 1'b0;
                        if (is_posted) begin
                            reg_done <= 1'b1;
                            reg_err  <= 2'b00;
                            state    <= ST_IDLE;
                        end else begin
                            cnt   <= '0;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // a response in the timeout cycle takes priority
                    if (uhost_resp_valid) begin
                        reg_done <= 1'b1;
                        state    <= ST_IDLE;
                        if (resp_match) begin
                            reg_err <= uhost_resp_cmd[26:25];
                            if (is_read) reg_rdata <= uhost_resp_data[RW-1:0];
                        end else begin
                            reg_err <= 2'b10;
                        end
                    end else if (timeout_hit) begin
                        reg_done <= 1'b1;
                        reg_err  <= 2'b11;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umi_reghost.sv
// Directed bench for umi_reghost with a completion scoreboard.
module tb_umi_reghost;

    logic        clk;
    logic        nreset;
    logic        reg_valid;
    logic        reg_write;
    logic        reg_posted;
    logic [63:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ready;
    logic        reg_done;
    logic [31:0] reg_rdata;
    logic [1:0]  reg_err;
    logic        uhost_req_valid;
    logic [31:0] uhost_req_cmd;
    logic [63:0] uhost_req_dstaddr;
    logic [63:0] uhost_req_srcaddr;
    logic [63:0] uhost_req_data;
    logic        uhost_req_ready;
    logic        uhost_resp_valid;
    logic [31:0] uhost_resp_cmd;
    logic [63:0] uhost_resp_dstaddr;
    logic [63:0] uhost_resp_srcaddr;
    logic [63:0] uhost_resp_data;
    logic        uhost_resp_ready;

    localparam logic [63:0] HOST = 64'h0000_0000_0000_1000;
    // expected command words: opcode | size(=2 for 32-bit) << 5
    localparam logic [31:0] CMD_RD   = 32'h0000_0041;
    localparam logic [31:0] CMD_WR   = 32'h0000_0043;
    localparam logic [31:0] CMD_PW   = 32'h0000_0045;
    localparam logic [31:0] RESP_RD  = 32'h0000_0002;
    localparam logic [31:0] RESP_WR  = 32'h0000_0004;

    umi_reghost #(
        .RW(32), .CW(32), .AW(64), .DW(64), .HOSTADDR(HOST), .TOW(4)
    ) dut (
        .clk(clk), .nreset(nreset),
        .reg_valid(reg_valid), .reg_write(reg_write), .reg_posted(reg_posted),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ready(reg_ready),
        .reg_done(reg_done), .reg_rdata(reg_rdata), .reg_err(reg_err),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push_exp(input logic [31:0] rdata, input logic [1:0] err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drive one request for a single cycle; DUT must be idle
    task automatic issue(input logic wr, input logic po, input logic [63:0] a,
                         input logic [31:0] d);
        check("issue_ready", reg_ready, 1'b1);
        reg_valid  = 1'b1;
        reg_write  = wr;
        reg_posted = po;
        reg_addr   = a;
        reg_wdata  = d;
        tick();
        reg_valid  = 1'b0;
        reg_write  = 1'b0;
        reg_posted = 1'b0;
    endtask

    task automatic respond(input logic [31:0] cmd, input logic [63:0] data);
        uhost_resp_valid = 1'b1;
        uhost_resp_cmd   = cmd;
        uhost_resp_data  = data;
        tick();
        uhost_resp_valid = 1'b0;
        uhost_resp_cmd   = '0;
        uhost_resp_data  = '0;
    endtask

    // completion monitor: every reg_done pulse pops one expectation
    always @(negedge clk) begin
        if (nreset && reg_done) begin
            if (q.size() == 0) begin
                check("spurious_done", reg_done, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_rdata", reg_rdata, e.rdata);
                check("sb_err", reg_err, e.err);
            end
        end
    end

    initial begin
        nreset             = 1'b0;
        reg_valid          = 1'b0;
        reg_write          = 1'b0;
        reg_posted         = 1'b0;
        reg_addr           = '0;
        reg_wdata          = '0;
        uhost_req_ready    = 1'b0;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = '0;
        uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0;
        uhost_resp_data    = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset values
        check("rst_ready", reg_ready, 1'b1);
        check("rst_done", reg_done, 1'b0);
        check("rst_rdata", reg_rdata, 32'h0);
        check("rst_err", reg_err, 2'b00);
        check("rst_req_valid", uhost_req_valid, 1'b0);
        check("rst_req_cmd", uhost_req_cmd, 32'h0);
        check("rst_srcaddr", uhost_req_srcaddr, HOST);
        check("rst_resp_ready", uhost_resp_ready, 1'b1);
        nreset = 1'b1;
        tick();

        // read @0x10, response 3 cycles after the request handshake
        uhost_req_ready = 1'b1;
        push_exp(32'hDEAD_BEEF, 2'b00);
        issue(1'b0, 1'b0, 64'h10, 32'h0);
        check("rd_req_valid", uhost_req_valid, 1'b1);
        check("rd_req_cmd", uhost_req_cmd, CMD_RD);
        check("rd_req_addr", uhost_req_dstaddr, 64'h10);
        check("rd_req_data", uhost_req_data, 64'h0);
        check("rd_req_src", uhost_req_srcaddr, HOST);
        tick();
        uhost_req_ready = 1'b0;
        check("rd_wait_valid", uhost_req_valid, 1'b0);
        check("rd_wait_ready", reg_ready, 1'b0);
        tick();
        tick();
        respond(RESP_RD, 64'h0000_0000_DEAD_BEEF);
        check("rd_done_lat", reg_done, 1'b1);
        tick();
        check("rd_done_pulse", reg_done, 1'b0);

        // write with uhost_req_ready held low for 4 cycles
        issue(1'b1, 1'b0, 64'h8, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            check("wr_hold_valid", uhost_req_valid, 1'b1);
            check("wr_hold_cmd", uhost_req_cmd, CMD_WR);
            check("wr_hold_addr", uhost_req_dstaddr, 64'h8);
            check("wr_hold_data", uhost_req_data, 64'h0000_0000_1234_5678);
            tick();
        end
        uhost_req_ready = 1'b1;
        check("wr_hs_valid", uhost_req_valid, 1'b1);
        tick();
        uhost_req_ready = 1'b0;
        check("wr_wait_valid", uhost_req_valid, 1'b0);
        push_exp(32'hDEAD_BEEF, 2'b00);
        respond(RESP_WR, 64'h0);
        check("wr_done", reg_done, 1'b1);
        tick();

        // posted write: done exactly 2 cycles after accept, then idle
        uhost_req_ready = 1'b1;
        push_exp(32'hDEAD_BEEF, 2'b00);
        issue(1'b1, 1'b1, 64'h4, 32'hA5A5_A5A5);
        check("pw_req_cmd", uhost_req_cmd, CMD_PW);
        check("pw_req_data", uhost_req_data, 64'h0000_0000_A5A5_A5A5);
        check("pw_no_done_c1", reg_done, 1'b0);
        tick();
        check("pw_done_c2", reg_done, 1'b1);
        check("pw_idle", reg_ready, 1'b1);
        check("pw_req_drop", uhost_req_valid, 1'b0);

        // read with error status 01; accepted in the done cycle of the posted write
        push_exp(32'h0BAD_F00D, 2'b01);
        issue(1'b0, 1'b0, 64'h20, 32'h0);
        tick();
        respond(RESP_RD | 32'h0200_0000, 64'hFFFF_FFFF_0BAD_F00D);
        check("err01_done", reg_done, 1'b1);
        tick();

        // read answered with a write-response opcode: err 10, rdata held
        push_exp(32'h0BAD_F00D, 2'b10);
        issue(1'b0, 1'b0, 64'h24, 32'h0);
        tick();
        respond(RESP_WR, 64'h0000_0000_1111_2222);
        check("badop_done", reg_done, 1'b1);
        tick();

        // timeout: no response, done after 15 WAIT cycles with err 11
        push_exp(32'h0BAD_F00D, 2'b11);
        issue(1'b0, 1'b0, 64'h30, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) begin
            check("to_no_done", reg_done, 1'b0);
            tick();
        end
        check("to_done", reg_done, 1'b1);
        check("to_idle", reg_ready, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        respond(RESP_RD, 64'h0000_0000_7777_7777);
        check("late_no_done", reg_done, 1'b0);
        check("late_idle", reg_ready, 1'b1);
        tick();
        check("late_no_done2", reg_done, 1'b0);

        // reset while waiting, then a stray response, then a normal read
        issue(1'b0, 1'b0, 64'h40, 32'h0);
        tick();
        tick();
        check("mid_wait", reg_ready, 1'b0);
        nreset = 1'b0;
        #1;
        check("mrst_ready", reg_ready, 1'b1);
        check("mrst_done", reg_done, 1'b0);
        check("mrst_rdata", reg_rdata, 32'h0);
        check("mrst_err", reg_err, 2'b00);
        check("mrst_req_valid", uhost_req_valid, 1'b0);
        tick();
        nreset = 1'b1;
        tick();
        respond(RESP_RD, 64'h0000_0000_0000_0055);
        check("stray_no_done", reg_done, 1'b0);
        check("stray_ready", reg_ready, 1'b1);
        tick();
        check("stray_no_done2", reg_done, 1'b0);
        push_exp(32'h5566_7788, 2'b00);
        issue(1'b0, 1'b0, 64'h50, 32'h0);
        tick();
        respond(RESP_RD, 64'h1122_3344_5566_7788);
        check("post_rst_done", reg_done, 1'b1);
        tick();
        tick();

        check("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
